// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encodings, the x0 register index and the control-output bundle.
`timescale 1ns/1ps
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_MC_STALL = 2'd2
  } state_e;

  // Architectural zero register; writes to it never create a dependency.
  localparam logic [4:0] REG_X0 = 5'd0;

  // Width of the post-redirect bubble counter (FLUSH_DEPTH 0..7).
  localparam int BUB_W = 3;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic pc_sel;
  } ctrl_t;

  // Free-running pipeline: every register advances, nothing is squashed.
  function automatic ctrl_t ctrl_normal();
    return '{pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1,
             ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0,
             pc_sel: 1'b0};
  endfunction

  // Taken branch: steer PC to the target and squash the two younger slots.
  function automatic ctrl_t ctrl_branch();
    ctrl_t c;
    c            = ctrl_normal();
    c.pc_sel     = 1'b1;
    c.ifid_flush = 1'b1;
    c.idex_flush = 1'b1;
    return c;
  endfunction

  // Post-redirect bubble: fetch continues but the fetched slot is discarded.
  function automatic ctrl_t ctrl_redirect();
    ctrl_t c;
    c            = ctrl_normal();
    c.ifid_flush = 1'b1;
    return c;
  endfunction

  // Multi-cycle EX occupancy: freeze the front end, bubble into MEM.
  function automatic ctrl_t ctrl_freeze();
    ctrl_t c;
    c             = '0;
    c.exmem_flush = 1'b1;
    return c;
  endfunction

  // Load-use: hold IF/ID for one cycle and send a bubble into EX.
  function automatic ctrl_t ctrl_load_use();
    ctrl_t c;
    c            = ctrl_normal();
    c.pc_write   = 1'b0;
    c.ifid_write = 1'b0;
    c.idex_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID instruction that needs the result of a
// load still sitting in EX. Purely combinational.
`timescale 1ns/1ps
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  output logic       load_use
);

  logic hit_rs1;
  logic hit_rs2;

  assign hit_rs1  = id_use_rs1 && (id_rs1 == ex_rd);
  assign hit_rs2  = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_mem_read && (ex_rd != REG_X0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: branch redirect with FLUSH_DEPTH fetch
// bubbles, multi-cycle EX freeze and load-use stall. Optional performance
// counters (stall_cnt, flush_cnt) are built when HAZARD_PERF_EN is defined.
`timescale 1ns/1ps
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       br_taken,
  input  logic       ex_busy,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       idex_write,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       pc_sel
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  state_e           state_q, state_d;
  logic [BUB_W-1:0] bub_cnt_q, bub_cnt_d;
  logic             load_use;
  logic             run_active;
  ctrl_t            ctrl;

  hazard_detect u_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .load_use    (load_use)
  );

  // The exit cycle of MC_STALL behaves exactly like a RUN cycle, so a branch
  // or load-use arriving as EX frees up is not lost.
  assign run_active = (state_q == ST_RUN) ||
                      ((state_q == ST_MC_STALL) && !ex_busy);

  // State register and bubble counter.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      bub_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bub_cnt_q <= bub_cnt_d;
    end
  end

  // Next-state logic: branch > ex_busy > load-use while running.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_d   = state_q;
    bub_cnt_d = bub_cnt_q;
    if (run_active) begin
      state_d = ST_RUN;
      if (br_taken) begin
        if (FLUSH_DEPTH > 0) begin
          state_d   = ST_REDIRECT;
          bub_cnt_d = BUB_W'(FLUSH_DEPTH);
        end
      end else if (ex_busy) begin
        state_d = ST_MC_STALL;
      end
    end else if (state_q == ST_REDIRECT) begin
      bub_cnt_d = bub_cnt_q - BUB_W'(1);
      if (bub_cnt_q <= BUB_W'(1)) begin
        state_d = ST_RUN;
      end
    end else if (state_q != ST_MC_STALL) begin
      state_d = ST_RUN;
    end
  end

  // Output decode from state and current inputs (zero-cycle latency).
  always_comb begin
    ctrl = ctrl_normal();
    if (run_active) begin
      if (br_taken)      ctrl = ctrl_branch();
      else if (ex_busy)  ctrl = ctrl_freeze();
      else if (load_use) ctrl = ctrl_load_use();
    end else if (state_q == ST_REDIRECT) begin
      ctrl = ctrl_redirect();
    end else if (state_q == ST_MC_STALL) begin
      ctrl = ctrl_freeze();
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign ifid_write  = ctrl.ifid_write;
  assign idex_write  = ctrl.idex_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_flush = ctrl.exmem_flush;
  assign pc_sel      = ctrl.pc_sel;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counts: front-end stall cycles and IF/ID flush cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!ctrl.pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (ctrl.ifid_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
